// File: rtl/queue_ctrl_8_4_pkg.sv
// Shared defaults and the q_state encoding for the queue controller slice.
// Used by queue_ctrl_8_4 (optional error flags: QUEUE_CTRL_ERR_EN).
package queue_pkg;

  localparam int Q_AW    = 3;
  localparam int Q_DW    = 4;
  localparam int Q_DEPTH = 8;

  typedef enum logic [1:0] {
    Q_EMPTY   = 2'd0,
    Q_PARTIAL = 2'd1,
    Q_FULL    = 2'd2
  } q_state_e;

endpackage

// File: rtl/queue_ctrl_8_4_ptr.sv
// (AW+1)-bit wrap pointer: MSB is the lap bit, low AW bits address the RAM.
module queue_ptr #(
  parameter int AW = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clr,
  input  logic        i_inc,
  output logic [AW:0] o_ptr
);

  logic [AW:0] r_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (i_clr) begin
      r_ptr <= '0;
    end else if (i_inc) begin
      r_ptr <= r_ptr + 1'b1;
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/queue_ctrl_8_4.sv
// Circular-queue controller sequencing an external 8x4 synchronous 1R1W RAM.
// Define QUEUE_CTRL_ERR_EN to build the sticky overflow/underflow flags.
module queue_ctrl_8_4
  import queue_pkg::*;
#(
  parameter int AW        = Q_AW,
  parameter int DW        = Q_DW,
  parameter int DEPTH     = Q_DEPTH,
  parameter int AFULL_TH  = 6,
  parameter int AEMPTY_TH = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  output logic          push_ready,
  input  logic          pop,
  output logic          pop_ready,
  output logic          pop_valid,
  output logic [DW-1:0] pop_data,
  input  logic          flush,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty,
  output logic [1:0]    q_state,
  output logic          overflow,
  output logic          underflow,
  output logic          ram_w_wr,
  output logic [DW-1:0] ram_w_din,
  output logic [AW-1:0] ram_w_addr,
  output logic [AW-1:0] ram_r_addr,
  input  logic [DW-1:0] ram_r_dout
);

  localparam logic [AW:0] DEPTH_V  = (AW+1)'(DEPTH);
  localparam logic [AW:0] AFULL_V  = (AW+1)'(AFULL_TH);
  localparam logic [AW:0] AEMPTY_V = (AW+1)'(AEMPTY_TH);

  logic [AW:0] w_wr_ptr;
  logic [AW:0] w_rd_ptr;
  logic        w_full;
  logic        w_empty;
  logic        w_push_acc;
  logic        w_pop_acc;
  logic [AW:0] w_count_nxt;
  q_state_e    w_state_nxt;

  logic [AW:0] r_count;
  q_state_e    r_state;
  logic        r_pop_valid;

  queue_ptr #(.AW(AW)) u_wr_ptr (
    .clk   (clk),
    .rst   (reset),
    .i_clr (flush),
    .i_inc (w_push_acc),
    .o_ptr (w_wr_ptr)
  );

  queue_ptr #(.AW(AW)) u_rd_ptr (
    .clk   (clk),
    .rst   (reset),
    .i_clr (flush),
    .i_inc (w_pop_acc),
    .o_ptr (w_rd_ptr)
  );

  assign w_empty = (w_wr_ptr == w_rd_ptr);
  assign w_full  = (w_wr_ptr[AW-1:0] == w_rd_ptr[AW-1:0]) &&
                   (w_wr_ptr[AW] != w_rd_ptr[AW]);

  // Full blocks push even alongside a pop: head and tail share an address then.
  assign push_ready = !w_full  && !flush && !reset;
  assign pop_ready  = !w_empty && !flush && !reset;
  assign w_push_acc = push && push_ready;
  assign w_pop_acc  = pop  && pop_ready;

  always_comb begin
    w_count_nxt = r_count;
    if (flush) begin
      w_count_nxt = '0;
    end else begin
      unique case ({w_push_acc, w_pop_acc})
        2'b10:   w_count_nxt = r_count + 1'b1;
        2'b01:   w_count_nxt = r_count - 1'b1;
        default: w_count_nxt = r_count;
      endcase
    end

    if (w_count_nxt == '0) begin
      w_state_nxt = Q_EMPTY;
    end else if (w_count_nxt == DEPTH_V) begin
      w_state_nxt = Q_FULL;
    end else begin
      w_state_nxt = Q_PARTIAL;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count     <= '0;
      r_state     <= Q_EMPTY;
      r_pop_valid <= 1'b0;
    end else begin
      r_count     <= w_count_nxt;
      r_state     <= w_state_nxt;
      r_pop_valid <= w_pop_acc;
    end
  end

`ifdef QUEUE_CTRL_ERR_EN
  logic r_overflow;
  logic r_underflow;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (flush) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (push && w_full)  r_overflow  <= 1'b1;
      if (pop  && w_empty) r_underflow <= 1'b1;
    end
  end

  assign overflow  = r_overflow;
  assign underflow = r_underflow;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

  assign count        = r_count;
  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (r_count >= AFULL_V);
  assign almost_empty = (r_count <= AEMPTY_V);
  assign q_state      = r_state;
  assign pop_valid    = r_pop_valid;
  assign pop_data     = ram_r_dout;

  assign ram_w_wr   = w_push_acc;
  assign ram_w_din  = push_data;
  assign ram_w_addr = w_wr_ptr[AW-1:0];
  assign ram_r_addr = w_rd_ptr[AW-1:0];

endmodule

// File: tb/tb_queue_ctrl_8_4.sv
// Self-checking bench for queue_ctrl_8_4: directed plan plus random traffic
// against a queue-based reference model and a behavioural synchronous RAM.
module tb_queue_ctrl_8_4;

  logic       clk = 1'b0;
  logic       reset;
  logic       push;
  logic [3:0] push_data;
  logic       push_ready;
  logic       pop;
  logic       pop_ready;
  logic       pop_valid;
  logic [3:0] pop_data;
  logic       flush;
  logic [3:0] count;
  logic       full, empty, almost_full, almost_empty;
  logic [1:0] q_state;
  logic       overflow, underflow;
  logic       ram_w_wr;
  logic [3:0] ram_w_din;
  logic [2:0] ram_w_addr;
  logic [2:0] ram_r_addr;
  logic [3:0] ram_r_dout;

  queue_ctrl_8_4 dut (
    .clk          (clk),
    .reset        (reset),
    .push         (push),
    .push_data    (push_data),
    .push_ready   (push_ready),
    .pop          (pop),
    .pop_ready    (pop_ready),
    .pop_valid    (pop_valid),
    .pop_data     (pop_data),
    .flush        (flush),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .q_state      (q_state),
    .overflow     (overflow),
    .underflow    (underflow),
    .ram_w_wr     (ram_w_wr),
    .ram_w_din    (ram_w_din),
    .ram_w_addr   (ram_w_addr),
    .ram_r_addr   (ram_r_addr),
    .ram_r_dout   (ram_r_dout)
  );

  always #5 clk = ~clk;

  // Behavioural 8x4 RAM: read address registered, data shown from the array.
  logic [3:0] mem [8];
  logic [2:0] raddr_q;
  always @(posedge clk) begin
    if (ram_w_wr) mem[ram_w_addr] <= ram_w_din;
    raddr_q <= ram_r_addr;
  end
  assign ram_r_dout = mem[raddr_q];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  logic [3:0] mq[$];
  int         widx;
  logic       exp_pv;
  logic [3:0] exp_pd;
  logic       exp_ovf, exp_unf;

  task automatic model_reset();
    mq.delete();
    widx    = 0;
    exp_pv  = 1'b0;
    exp_pd  = '0;
    exp_ovf = 1'b0;
    exp_unf = 1'b0;
  endtask

  // Called just after a falling edge: drive, check, advance model, wait a cycle.
  task automatic step(input logic p, input logic [3:0] d, input logic po, input logic fl);
    int   cnt;
    logic e_pr, e_por, pa, pa2;
    push = p; push_data = d; pop = po; flush = fl;
    #1;
    cnt   = mq.size();
    e_pr  = (cnt < 8) && !fl;
    e_por = (cnt > 0) && !fl;
    pa    = p && e_pr;
    pa2   = po && e_por;
    chk("count", 32'(count), 32'(cnt));
    chk("empty", 32'(empty), 32'(cnt == 0));
    chk("full", 32'(full), 32'(cnt == 8));
    chk("almost_full", 32'(almost_full), 32'(cnt >= 6));
    chk("almost_empty", 32'(almost_empty), 32'(cnt <= 2));
    chk("q_state", 32'(q_state), (cnt == 0) ? 32'd0 : (cnt == 8) ? 32'd2 : 32'd1);
    chk("push_ready", 32'(push_ready), 32'(e_pr));
    chk("pop_ready", 32'(pop_ready), 32'(e_por));
    chk("ram_w_wr", 32'(ram_w_wr), 32'(pa));
    if (pa) begin
      chk("ram_w_addr", 32'(ram_w_addr), 32'(widx));
      chk("ram_w_din", 32'(ram_w_din), 32'(d));
    end
    chk("pop_valid", 32'(pop_valid), 32'(exp_pv));
    if (exp_pv) chk("pop_data", 32'(pop_data), 32'(exp_pd));
`ifdef QUEUE_CTRL_ERR_EN
    chk("overflow", 32'(overflow), 32'(exp_ovf));
    chk("underflow", 32'(underflow), 32'(exp_unf));
`else
    chk("overflow", 32'(overflow), 32'd0);
    chk("underflow", 32'(underflow), 32'd0);
`endif
    if (fl) begin
      mq.delete();
      widx    = 0;
      exp_pv  = 1'b0;
      exp_ovf = 1'b0;
      exp_unf = 1'b0;
    end else begin
      if (p && cnt == 8) exp_ovf = 1'b1;
      if (po && cnt == 0) exp_unf = 1'b1;
      exp_pv = pa2;
      if (pa2) exp_pd = mq.pop_front();
      if (pa) begin
        mq.push_back(d);
        widx = (widx + 1) % 8;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 4'h0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; push = 1'b0; push_data = '0; pop = 1'b0; flush = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Reset state and idle
    idle();
    idle();

    // Fill 1..8, then a 9th push against full
    for (int i = 1; i <= 8; i++) step(1'b1, 4'(i), 1'b0, 1'b0);
    step(1'b1, 4'h9, 1'b0, 1'b0);

    // Drain back-to-back
    for (int i = 0; i < 8; i++) step(1'b0, 4'h0, 1'b1, 1'b0);
    idle();
    idle();

    // Wrap-around: pointers restart from 0, push 5/pop 5, then push 6/pop 6
    step(1'b0, 4'h0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 4'(i + 3), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 4'h0, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b1, 4'(4'hA + i), 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 4'h0, 1'b1, 1'b0);
    idle();

    // Simultaneous push+pop at count 3, at full, at empty
    for (int i = 0; i < 3; i++) step(1'b1, 4'(i + 1), 1'b0, 1'b0);
    step(1'b1, 4'hC, 1'b1, 1'b0);
    step(1'b1, 4'hD, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 4'(i + 5), 1'b0, 1'b0);
    step(1'b1, 4'hF, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b0, 4'h0, 1'b1, 1'b0);
    step(1'b1, 4'h6, 1'b1, 1'b0);
    idle();

    // Flush at count 4 with push and pop asserted; errors provoked beforehand
    step(1'b0, 4'h0, 1'b1, 1'b0);
    step(1'b0, 4'h0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 4'(i + 7), 1'b0, 1'b0);
    step(1'b1, 4'h5, 1'b1, 1'b1);
    idle();

    // Async reset mid-burst
    for (int i = 0; i < 3; i++) step(1'b1, 4'(i + 2), 1'b0, 1'b0);
    push = 1'b1; pop = 1'b1; flush = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_empty", 32'(empty), 32'd1);
    chk("arst_full", 32'(full), 32'd0);
    chk("arst_q_state", 32'(q_state), 32'd0);
    chk("arst_pop_valid", 32'(pop_valid), 32'd0);
    chk("arst_ram_w_wr", 32'(ram_w_wr), 32'd0);
    chk("arst_push_ready", 32'(push_ready), 32'd0);
    chk("arst_almost_empty", 32'(almost_empty), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    idle();

    // Random traffic with shifting push/pop bias
    for (int blk = 0; blk < 8; blk++) begin
      int pp, op;
      pp = (blk % 2 == 0) ? 75 : 30;
      op = (blk % 2 == 0) ? 30 : 75;
      for (int i = 0; i < 80; i++) begin
        step(($urandom_range(0, 99) < pp), 4'($urandom), ($urandom_range(0, 99) < op),
             ($urandom_range(0, 99) < 3));
      end
    end
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got=running expected=done");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/queue_ctrl_8_4.md
Name: queue_ctrl_8_4

Overview:
- FIFO queue controller that sequences the 8-entry x 4-bit synchronous 1R1W RAM (xst_ram_1r1w_synch_8_4_0) as a circular queue.
- Owns the head and tail pointers, occupancy, full/empty, flush and the push/pop handshakes.
- Drives the RAM write and read ports and returns popped data.
- Holds no data storage itself. It sits between queue users and the RAM instance at the next level up.

Parameters:
- AW, 3, RAM address width.
- DW, 4, data width.
- DEPTH, 8, number of entries; must equal 2**AW.
- AFULL_TH, 6, almost_full asserted when count >= AFULL_TH.
- AEMPTY_TH, 2, almost_empty asserted when count <= AEMPTY_TH.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- push  in  1  push request.
- push_data  in  DW  data to enqueue.
- push_ready  out  1  push accepted this cycle if push=1.
- pop  in  1  pop request.
- pop_ready  out  1  pop accepted this cycle if pop=1.
- pop_valid  out  1  pop_data valid; asserted one cycle after an accepted pop.
- pop_data  out  DW  dequeued data.
- flush  in  1  synchronous queue clear.
- count  out  AW+1  occupancy, 0..DEPTH.
- full, empty, almost_full, almost_empty  out  1 each  status flags.
- q_state  out  2  0=EMPTY, 1=PARTIAL, 2=FULL.
- overflow, underflow  out  1 each  sticky error flags (see Optional Feature).
- ram_w_wr  out  1  RAM write enable.
- ram_w_din  out  DW  RAM write data.
- ram_w_addr  out  AW  RAM write address.
- ram_r_addr  out  AW  RAM read address.
- ram_r_dout  in  DW  RAM read data; reflects the address registered at the previous edge.

Behaviour:
- Pointers:
  - wr_ptr and rd_ptr are AW+1 bits; the MSB is the wrap bit.
  - empty = (wr_ptr == rd_ptr).
  - full = low bits equal and MSBs differ.
  - Both pointers increment modulo 2**(AW+1); 7 -> 8 wraps the low address to 0.
- Handshake:
  - push_ready = !full & !flush & !reset.
  - pop_ready = !empty & !flush & !reset.
  - push_acc = push & push_ready; pop_acc = pop & pop_ready.
- Simultaneous push and pop:
  - When full: push rejected (head address == tail address would corrupt the read); pop proceeds.
  - When empty: pop rejected; push proceeds.
  - Otherwise both are accepted; count unchanged.
- RAM drive (combinational):
  - ram_w_wr = push_acc.
  - ram_w_addr = wr_ptr[AW-1:0].
  - ram_w_din = push_data.
  - ram_r_addr = rd_ptr[AW-1:0] (always presented; the RAM registers it).
- Pop latency:
  - pop_valid is a register set to pop_acc, giving 1-cycle latency.
  - pop_data = ram_r_dout (passthrough, meaningful only when pop_valid = 1).
- Back-to-back pops deliver one word per cycle.
- Count:
  - +1 on push only, -1 on pop only, unchanged on both or neither.
  - count never exceeds DEPTH and never underflows.
- State machine q_state (registered, next state from next count):
  - EMPTY -> PARTIAL on a push.
  - PARTIAL -> FULL when count reaches DEPTH.
  - PARTIAL -> EMPTY when count reaches 0.
  - FULL -> PARTIAL on a pop.
  - Any state -> EMPTY on flush.
- Flush:
  - Next edge: pointers = 0, count = 0, q_state = EMPTY, pop_valid = 0.
  - Flush overrides push and pop in the same cycle; both are rejected.
- Reset values:
  - wr_ptr = rd_ptr = 0, count = 0, q_state = EMPTY, pop_valid = 0.
  - empty = 1, full = 0, almost_empty = 1, almost_full = 0.
  - overflow = underflow = 0.
  - ram_w_wr = 0 while reset is high.
- Reset asserted mid-operation clears all state immediately; RAM contents are not cleared and are treated as garbage.

Optional Feature:
- Macro QUEUE_CTRL_ERR_EN.
- Defined:
  - overflow sets on push & full & !flush.
  - underflow sets on pop & empty & !flush.
  - Both are sticky until reset or flush.
- Undefined: overflow and underflow are tied to 0 and no error registers are built.

Decomposition:
- Package queue_pkg holds:
  - AW, DW and DEPTH defaults.
  - q_state encoding constants: Q_EMPTY = 2'd0, Q_PARTIAL = 2'd1, Q_FULL = 2'd2.
- Natural sub-module: queue_ptr, an (AW+1)-bit wrap pointer with increment and clear. It is instantiated twice, as the write pointer and the read pointer.
- The RAM is instantiated outside this block.

Test Plan:
- Reset then idle: count = 0, empty = 1, q_state = 0, pop_ready = 0, ram_w_wr = 0.
- Push 0x1..0x8 on consecutive cycles: count = 8, full = 1, q_state = 2, almost_full asserted from count = 6, 9th push has push_ready = 0. With QUEUE_CTRL_ERR_EN, overflow = 1.
- Pop 8 times back-to-back from full: pop_valid high for 8 cycles, each one cycle after its pop, with pop_data = 0x1..0x8 in order; then empty = 1.
- Wrap-around: push 5, pop 5, push 6 entries: ram_w_addr sequence 5,6,7,0,1,2; pops return the 6 values in order.
- Simultaneous events:
  - push and pop at count = 3: count stays 3, data order preserved.
  - push and pop at full: only the pop is accepted, count becomes 7.
  - push and pop at empty: only the push is accepted, count becomes 1, pop_valid = 0.
- Flush at count = 4 with push and pop both asserted: next cycle count = 0, empty = 1, pop_valid = 0, error flags cleared.
- Async reset pulse mid-burst: outputs return to reset values before the next clock edge.
